// File: rtl/uart_status_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_status_tx_if
// Description : Request/response bundle between the lock state machine and
//               the UART status transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_status_tx_if;
  logic        req;      // single-cycle send request
  logic [2:0]  msg_sel;  // message code, captured with req
  logic [23:0] digits;   // six BCD digits, [23:20] leftmost
  logic        tx;       // UART serial line, idle high
  logic        busy;     // message in progress
  logic        done;     // one-cycle pulse after the final stop bit

  // Requester side: raises requests and watches the line/status.
  modport master (
    output req, msg_sel, digits,
    input  tx, busy, done
  );

  // Transmitter side.
  modport slave (
    input  req, msg_sel, digits,
    output tx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_status_tx
// Description : Sends a fixed ASCII status message or a formatted clock
//               readout ("D5D4:D3D2:D1D0\r\n") as 8N1 UART frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_status_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_status_tx_if.slave  bus
);

  localparam logic [15:0] c_BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ASCII for one BCD digit; non-decimal nibbles print as '?'.
  function automatic logic [7:0] f_digit(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  // Number of bytes in each message.
  function automatic logic [3:0] f_msg_len(input logic [2:0] sel);
    logic [3:0] len;
    case (sel)
      3'd0:    len = 4'd4;
      3'd1:    len = 4'd5;
      3'd2:    len = 4'd6;
      3'd3:    len = 4'd10;
      default: len = 4'd3;
    endcase
    return len;
  endfunction

  // Message ROM: byte content by message code and byte index.
  function automatic logic [7:0] f_rom_byte(input logic [2:0]  sel,
                                            input logic [23:0] dig,
                                            input logic [3:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      3'd0: begin
        case (idx)
          4'd0:    b = 8'h4F;  // O
          4'd1:    b = 8'h4B;  // K
          4'd2:    b = 8'h0D;
          4'd3:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      3'd1: begin
        case (idx)
          4'd0:    b = 8'h45;  // E
          4'd1:    b = 8'h52;  // R
          4'd2:    b = 8'h52;  // R
          4'd3:    b = 8'h0D;
          4'd4:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      3'd2: begin
        case (idx)
          4'd0:    b = 8'h4C;  // L
          4'd1:    b = 8'h4F;  // O
          4'd2:    b = 8'h43;  // C
          4'd3:    b = 8'h4B;  // K
          4'd4:    b = 8'h0D;
          4'd5:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      3'd3: begin
        case (idx)
          4'd0:    b = f_digit(dig[23:20]);
          4'd1:    b = f_digit(dig[19:16]);
          4'd2:    b = 8'h3A;  // :
          4'd3:    b = f_digit(dig[15:12]);
          4'd4:    b = f_digit(dig[11:8]);
          4'd5:    b = 8'h3A;  // :
          4'd6:    b = f_digit(dig[7:4]);
          4'd7:    b = f_digit(dig[3:0]);
          4'd8:    b = 8'h0D;
          4'd9:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      default: begin
        case (idx)
          4'd0:    b = 8'h3F;  // ?
          4'd1:    b = 8'h0D;
          4'd2:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
    endcase
    return b;
  endfunction

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [3:0]  r_idx;
  logic [2:0]  r_sel;
  logic [23:0] r_digits;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [15:0] w_baud_nxt;
  logic [2:0]  w_bit_nxt;
  logic [3:0]  w_idx_nxt;
  logic [2:0]  w_sel_nxt;
  logic [23:0] w_digits_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_tx_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  logic        w_bit_end;
  logic        w_last_byte;
  logic [3:0]  w_len;
  logic [7:0]  w_first_byte;
  logic [7:0]  w_next_byte;

  assign w_bit_end    = (r_baud == c_BAUD_MAX);
  assign w_len        = f_msg_len(r_sel);
  assign w_last_byte  = (r_idx == (w_len - 4'd1));
  // The first byte is looked up from the live inputs because they are
  // captured on the same edge that loads the shift register.
  assign w_first_byte = f_rom_byte(bus.msg_sel, bus.digits, 4'd0);
  assign w_next_byte  = f_rom_byte(r_sel, r_digits, r_idx + 4'd1);

  // Next-state, datapath and registered-output values for the frame sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = w_bit_end ? 16'd0 : (r_baud + 16'd1);
    w_bit_nxt    = r_bit;
    w_idx_nxt    = r_idx;
    w_sel_nxt    = r_sel;
    w_digits_nxt = r_digits;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = 16'd0;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (bus.req) begin
          w_state_nxt  = S_START;
          w_sel_nxt    = bus.msg_sel;
          w_digits_nxt = bus.digits;
          w_idx_nxt    = 4'd0;
          w_bit_nxt    = 3'd0;
          w_shift_nxt  = w_first_byte;
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          if (w_last_byte) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_START;
            w_idx_nxt   = r_idx + 4'd1;
            w_shift_nxt = w_next_byte;
            w_tx_nxt    = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = 16'd0;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= 16'd0;
      r_bit    <= 3'd0;
      r_idx    <= 4'd0;
      r_sel    <= 3'd0;
      r_digits <= 24'd0;
      r_shift  <= 8'd0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_idx    <= w_idx_nxt;
      r_sel    <= w_sel_nxt;
      r_digits <= w_digits_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_status_tx
// Description : Scoreboard bench for uart_status_tx (CLKS_PER_BIT = 4).
//               Stimulus queues expected bytes and done cycles; a monitor
//               decodes tx frames and done pulses and checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_status_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  int         done_q [$];

  uart_status_tx_if bus ();

  uart_status_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle number: cycle N starts at the posedge that sets cyc to N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue n bytes, taken from the most significant end of the vector.
  task automatic push_bytes(input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[79-8*i -: 8]);
  endtask

  // Advance to 1 time unit after the posedge that starts cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle request issued in the current cycle; returns its cycle number.
  task automatic send(input logic [2:0] sel, input logic [23:0] dig, output int n);
    bus.req     = 1'b1;
    bus.msg_sel = sel;
    bus.digits  = dig;
    n = cyc;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  // Monitor: done-pulse scoreboard and 8N1 frame decoder sampled mid-bit.
  int         d_st  = 0;
  int         d_cnt = 0;
  logic [7:0] d_sh  = 8'h00;
  logic [7:0] d_exp;
  int         d_done;

  always @(negedge clk) begin
    if (rst) begin
      d_st  = 0;
      d_cnt = 0;
    end else begin
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          d_done = done_q.pop_front();
          chk("done_cycle", cyc, d_done);
          chk("done_tx", {31'd0, bus.tx}, 32'd1);
          chk("done_busy", {31'd0, bus.busy}, 32'd0);
        end
      end
      if (d_st == 0) begin
        if (bus.tx === 1'b0) begin
          d_st  = 1;
          d_cnt = 0;
        end
      end else begin
        d_cnt++;
        if (d_cnt == 2) chk("start_bit", {31'd0, bus.tx}, 32'd0);
        if (d_cnt >= 6 && d_cnt <= 34 && ((d_cnt - 6) % 4) == 0)
          d_sh[(d_cnt-6)/4] = bus.tx;
        if (d_cnt == 38) begin
          chk("stop_bit", {31'd0, bus.tx}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("byte_unexpected", {24'd0, d_sh}, 32'h100);
          end else begin
            d_exp = exp_q.pop_front();
            chk("byte", {24'd0, d_sh}, {24'd0, d_exp});
          end
        end
        if (d_cnt == 39) d_st = 0;
      end
    end
  end

  int n;
  int m;
  int dummy;

  initial begin
    bus.req     = 1'b0;
    bus.msg_sel = 3'd0;
    bus.digits  = 24'd0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", {31'd0, bus.tx}, 32'd1);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_done", {31'd0, bus.done}, 32'd0);
    end
    @(posedge clk);
    #1;

    // "OK\r\n" with busy window and start-bit timing.
    send(3'd0, 24'd0, n);
    push_bytes({32'h4F4B0D0A, 48'h0}, 4);
    done_q.push_back(n + 1 + 10*4*CPB);
    for (int c = n + 1; c <= n + 161; c++) begin
      goto(c);
      @(negedge clk);
      chk("busy_window", {31'd0, bus.busy}, {31'd0, (c <= n + 160)});
      if (c == n + 1) chk("start_first", {31'd0, bus.tx}, 32'd0);
      if (c == n + 4) chk("start_last", {31'd0, bus.tx}, 32'd0);
      if (c == n + 5) chk("data_bit0", {31'd0, bus.tx}, 32'd1);
    end
    goto(n + 170);

    // Clock readout, digits changed after capture.
    send(3'd3, 24'h123459, n);
    push_bytes(80'h31323A33343A35390D0A, 10);
    done_q.push_back(n + 401);
    goto(n + 2);
    bus.digits = 24'd0;
    goto(n + 410);

    // Non-decimal digits, then an undefined message code.
    send(3'd3, 24'hA0000F, n);
    push_bytes(80'h3F303A30303A303F0D0A, 10);
    done_q.push_back(n + 401);
    goto(n + 410);
    send(3'd6, 24'd0, n);
    push_bytes({24'h3F0D0A, 56'h0}, 3);
    done_q.push_back(n + 121);
    goto(n + 130);

    // Request while busy is dropped; request in the done cycle is taken.
    send(3'd1, 24'd0, n);
    push_bytes({40'h4552520D0A, 40'h0}, 5);
    done_q.push_back(n + 201);
    goto(n + 20);
    send(3'd2, 24'd0, dummy);
    goto(n + 201);
    send(3'd2, 24'd0, m);
    push_bytes({48'h4C4F434B0D0A, 32'h0}, 6);
    done_q.push_back(m + 241);
    chk("done_cycle_req_cycle", m, n + 201);
    @(negedge clk);
    chk("rearm_busy", {31'd0, bus.busy}, 32'd1);
    chk("rearm_tx", {31'd0, bus.tx}, 32'd0);
    goto(m + 250);

    // Reset during data bit 2 of byte index 2 aborts the message.
    send(3'd0, 24'd0, n);
    push_bytes({16'h4F4B, 64'h0}, 2);
    goto(n + 94);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", {31'd0, bus.tx}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    goto(n + 200);
    send(3'd0, 24'd0, n);
    push_bytes({32'h4F4B0D0A, 48'h0}, 4);
    done_q.push_back(n + 161);
    goto(n + 170);

    // Drain with a bounded wait.
    for (int i = 0; i < 1000 && (done_q.size() != 0 || exp_q.size() != 0); i++)
      @(posedge clk);
    #1;
    chk("bytes_left", exp_q.size(), 32'd0);
    chk("done_left", done_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_status_tx.md
# uart_status_tx

UART response transmitter for the lock/timer design: the transmit-side counterpart of the command receiver. On a one-cycle request it selects a fixed ASCII status message or a formatted countdown-clock readout, then serializes it on `tx` as 8N1 frames. It sits between the lock state machine (which raises requests) and the board `tx` pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input 1: single-cycle send request; sampled only in IDLE.
- `msg_sel` input 3: message code, latched with `req`.
- `digits` input 24: six BCD digits, latched with `req`; `[23:20]` is the leftmost digit, `[3:0]` the rightmost.
- `tx` output 1: UART serial line; idle high.
- `busy` output 1: high while a message is in progress.
- `done` output 1: one-cycle pulse when the last stop bit completes.

## Operation
- Messages, sent as bytes in order:
  - `msg_sel=0`: "OK\r\n" (0x4F 0x4B 0x0D 0x0A), 4 bytes.
  - `msg_sel=1`: "ERR\r\n", 5 bytes.
  - `msg_sel=2`: "LOCK\r\n", 6 bytes.
  - `msg_sel=3`: clock readout "D5D4:D3D2:D1D0\r\n", 10 bytes.
  - `msg_sel=4..7`: "?\r\n" (0x3F 0x0D 0x0A), 3 bytes.
- Digit encoding:
  - A digit value 0..9 is sent as 0x30 plus the value.
  - A digit value 10..15 is sent as 0x3F ('?').
  - The colon is 0x3A.
- Message length and byte content come from a combinational ROM indexed by the latched `msg_sel` and a 4-bit byte index.
- Latching: `msg_sel` and `digits` are captured on the accepted `req`. Later input changes do not affect the message in flight.
- Frame format: one start bit (0), eight data bits LSB first, one stop bit (1). No parity.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on `req`. This loads byte index 0 and clears the bit counter.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 × `CLKS_PER_BIT` cycles. A 3-bit counter tracks the bit number.
  - STOP → START if more bytes remain; the index increments and the next byte loads.
  - STOP → IDLE after the last byte; `done` pulses.
- `req` while `busy` is ignored, with no queuing.
- Baud counter: 16 bits. It counts 0..`CLKS_PER_BIT-1` and wraps.
- Output `tx` is registered from the FSM state and the shift-register LSB.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset dominates any other condition in the same cycle.
- Request latency:
  - `req` at cycle N (in IDLE) gives `busy`=1 and `tx`=0 (start bit) from cycle N+1.
  - The start bit holds through cycle N+`CLKS_PER_BIT`.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit's last cycle, with no idle gap.
- For a message of L bytes, `done`=1 and `busy`=0 at cycle N+1+10×L×`CLKS_PER_BIT`.
- `tx` is 1 in the `done` cycle and holds 1 while idle.
- A `req` in the `done` cycle is accepted: the FSM is in IDLE then, and the next message starts the following cycle.
- Reset mid-operation: on the cycle after `rst`, `tx`=1, `busy`=0 and `done`=0. No `done` is emitted for the aborted message.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset, then idle for 50 cycles -> `tx`=1, `busy`=0, `done`=0 throughout.
- `req` with `msg_sel=0` at cycle 10 -> `tx` decodes 0x4F 0x4B 0x0D 0x0A, each bit 4 cycles wide; `done` pulses exactly at cycle 171; `busy` is high for cycles 11..170.
- `req` with `msg_sel=3`, `digits`=0x123459; change `digits` to 0 two cycles later -> decoded "12:34:59\r\n" (0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x39 0x0D 0x0A); `done` 401 cycles after `req`.
- `msg_sel=3` with `digits`=0xA0000F -> first byte 0x3F, ninth-from-end digit bytes 0x30, sixth digit 0x3F. Also `msg_sel=6` -> "?\r\n".
- `req` with `msg_sel=1`, then a second `req` (`msg_sel=2`) 20 cycles later -> only "ERR\r\n" is sent. Then `req` with `msg_sel=2` in the `done` cycle -> "LOCK\r\n" with its start bit on the next cycle.
- Assert `rst` during the third data bit of byte 2 -> next cycle `tx`=1 and `busy`=0; no `done`; a fresh `req` afterwards transmits correctly from byte 0.
